// File: rtl/mtm_pkg.sv
// Shared definitions for the matrix-transpose pipeline: default geometry,
// bank bookkeeping types and the flat-index to row/column split.
package mtm_pkg;

    localparam int MTM_DATA_WIDTH = 8;
    localparam int MTM_NUM_PE     = 4;

    typedef logic bank_sel_t;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    typedef struct packed {
        bank_state_t bank0;
        bank_state_t bank1;
        bank_sel_t   wr_bank;
        bank_sel_t   rd_bank;
    } feeder_dbg_t;

    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
    } rc_t;

    // Row-major split of a flat element index; num_pe is always a power of two.
    function automatic rc_t elem_to_rc(input logic [15:0] idx, input int unsigned num_pe);
        rc_t rc;
        rc.row = 16'(idx / 16'(num_pe));
        rc.col = 16'(idx % 16'(num_pe));
        return rc;
    endfunction

endpackage

// File: rtl/mtm_row_feeder_if.sv
// Bundle between the element-serial upstream, the row feeder and mtm_unit.
// Handshake: an element transfers on a posedge where in_val && in_rdy (and clear is low);
// in_rdy never depends on in_val, and out_val has no ready because mtm_unit cannot stall.
interface mtm_row_feeder_if
    import mtm_pkg::*;
#(
    parameter int DATA_WIDTH = MTM_DATA_WIDTH,
    parameter int NUM_PE     = MTM_NUM_PE
);
    localparam int ROW_W = $clog2(NUM_PE);

    logic                  clear;
    logic                  in_val;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_val;
    logic [DATA_WIDTH-1:0] out_row [0:NUM_PE-1];
    logic [ROW_W-1:0]      out_idx;
    logic                  out_last;

    modport slave (
        input  clear,
        input  in_val,
        input  in_data,
        output in_rdy,
        output out_val,
        output out_row,
        output out_idx,
        output out_last
    );

    modport master (
        output clear,
        output in_val,
        output in_data,
        input  in_rdy,
        input  out_val,
        input  out_row,
        input  out_idx,
        input  out_last
    );

endinterface

// File: rtl/mtm_bank.sv
// One NUM_PE x NUM_PE element store: single-element write, whole-row combinational read.
module mtm_bank
    import mtm_pkg::*;
#(
    parameter int DATA_WIDTH = MTM_DATA_WIDTH,
    parameter int NUM_PE     = MTM_NUM_PE,
    localparam int ROW_W     = $clog2(NUM_PE)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ROW_W-1:0]      wr_row,
    input  logic [ROW_W-1:0]      wr_col,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ROW_W-1:0]      rd_row,
    output logic [DATA_WIDTH-1:0] rd_data [0:NUM_PE-1]
);

    // Contents are deliberately not reset; the feeder's full flags gate every read.
    logic [DATA_WIDTH-1:0] mem [0:NUM_PE-1][0:NUM_PE-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    for (genvar c = 0; c < NUM_PE; c++) begin : g_rd
        assign rd_data[c] = mem[rd_row][c];
    end

endmodule

// File: rtl/mtm_row_feeder.sv
// Ping-pong matrix assembler: fills one bank element by element while the other
// streams complete rows to mtm_unit, one row per cycle, never splitting a matrix.
module mtm_row_feeder
    import mtm_pkg::*;
#(
    parameter int DATA_WIDTH = MTM_DATA_WIDTH,
    parameter int NUM_PE     = MTM_NUM_PE
) (
    input  logic                clk,
    input  logic                rst,
    mtm_row_feeder_if.slave     bus,
    output feeder_dbg_t         dbg
);

    localparam int ROW_W     = $clog2(NUM_PE);
    localparam int ELEM_W    = $clog2(NUM_PE * NUM_PE);
    localparam int ELEM_LAST = NUM_PE * NUM_PE - 1;

    logic [ELEM_W-1:0] elem_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [1:0]        full;
    bank_sel_t         wr_bank;
    bank_sel_t         rd_bank;

    logic                  out_val_q;
    logic                  out_last_q;
    logic [ROW_W-1:0]      out_idx_q;
    logic [DATA_WIDTH-1:0] out_row_q [0:NUM_PE-1];

    logic                  accept;
    logic                  last_elem;
    logic                  emit;
    logic                  last_row;
    logic [1:0]            bank_we;
    rc_t                   wr_rc;
    logic [ROW_W-1:0]      wr_row;
    logic [ROW_W-1:0]      wr_col;
    logic [DATA_WIDTH-1:0] rd_row0 [0:NUM_PE-1];
    logic [DATA_WIDTH-1:0] rd_row1 [0:NUM_PE-1];
    bank_state_t           bank_st [0:1];
    logic                  unused_rc_bits;

    // With one bank full the writer already points at the other, so this only
    // drops when both banks hold complete matrices.
    assign bus.in_rdy = rst && !full[wr_bank];
    assign accept     = bus.in_val && bus.in_rdy && !bus.clear;
    assign last_elem  = (elem_cnt == ELEM_W'(ELEM_LAST));
    assign emit       = full[rd_bank];
    assign last_row   = (row_cnt == ROW_W'(NUM_PE - 1));

    always_comb begin
        wr_rc = elem_to_rc(16'(elem_cnt), NUM_PE);
    end

    assign wr_row         = wr_rc.row[ROW_W-1:0];
    assign wr_col         = wr_rc.col[ROW_W-1:0];
    assign unused_rc_bits = ^{wr_rc.row[15:ROW_W], wr_rc.col[15:ROW_W]};

    assign bank_we[0] = accept && (wr_bank == 1'b0);
    assign bank_we[1] = accept && (wr_bank == 1'b1);

    mtm_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_PE(NUM_PE)) u_bank0 (
        .clk     (clk),
        .we      (bank_we[0]),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (bus.in_data),
        .rd_row  (row_cnt),
        .rd_data (rd_row0)
    );

    mtm_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_PE(NUM_PE)) u_bank1 (
        .clk     (clk),
        .we      (bank_we[1]),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (bus.in_data),
        .rd_row  (row_cnt),
        .rd_data (rd_row1)
    );

    // Write and read sides touch different full bits on any given edge, so both
    // updates can land together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            elem_cnt   <= '0;
            row_cnt    <= '0;
            full       <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            out_val_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_idx_q  <= '0;
            for (int c = 0; c < NUM_PE; c++) begin
                out_row_q[c] <= '0;
            end
        end else begin
            if (bus.clear) begin
                elem_cnt <= '0;
            end else if (accept) begin
                if (last_elem) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    elem_cnt      <= '0;
                end else begin
                    elem_cnt <= elem_cnt + ELEM_W'(1);
                end
            end

            if (emit) begin
                out_val_q  <= 1'b1;
                out_last_q <= last_row;
                out_idx_q  <= row_cnt;
                for (int c = 0; c < NUM_PE; c++) begin
                    out_row_q[c] <= rd_bank ? rd_row1[c] : rd_row0[c];
                end
                if (last_row) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    row_cnt       <= '0;
                end else begin
                    row_cnt <= row_cnt + ROW_W'(1);
                end
            end else begin
                out_val_q  <= 1'b0;
                out_last_q <= 1'b0;
            end
        end
    end

    assign bus.out_val  = out_val_q;
    assign bus.out_last = out_last_q;
    assign bus.out_idx  = out_idx_q;
    assign bus.out_row  = out_row_q;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st[b] = BANK_EMPTY;
            if (full[b]) begin
                bank_st[b] = (rd_bank == 1'(b) && row_cnt != '0) ? BANK_DRAINING : BANK_FULL;
            end else if (wr_bank == 1'(b) && elem_cnt != '0) begin
                bank_st[b] = BANK_FILLING;
            end
        end
        dbg.bank0   = bank_st[0];
        dbg.bank1   = bank_st[1];
        dbg.wr_bank = wr_bank;
        dbg.rd_bank = rd_bank;
    end

endmodule

// File: tb/tb_mtm_row_feeder.sv
// Bench for mtm_row_feeder: directed matrices plus random traffic, scored against
// a queue of expected rows built from whole accepted matrices.
module tb_mtm_row_feeder;
    import mtm_pkg::*;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int RW = 2;
    localparam int W  = RW + DW * N;

    logic        clk = 1'b0;
    logic        rst;
    feeder_dbg_t dbg;

    mtm_row_feeder_if #(.DATA_WIDTH(DW), .NUM_PE(N)) bus ();

    mtm_row_feeder #(.DATA_WIDTH(DW), .NUM_PE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .dbg (dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0]    exp_q[$];
    logic [DW-1:0]   partial[$];
    logic [DW*N-1:0] held_row;
    logic [RW-1:0]   held_idx;
    int              n_checks = 0;
    int              n_errors = 0;
    int              cycle = 0;
    int              rows_seen = 0;
    int              run_len = 0;
    int              max_run = 0;
    int              last_acc_cycle = 0;
    int              first_row_cycle = -1;
    logic            last_acc = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [DW*N-1:0] flat_row();
        logic [DW*N-1:0] f;
        for (int c = 0; c < N; c++) begin
            f[c*DW +: DW] = bus.out_row[c];
        end
        return f;
    endfunction

    function automatic logic [DW-1:0] m_elem(input int sel, input int i, input int j);
        logic [DW-1:0] m0;
        m0 = DW'(8'h10 * i + 8'h0A + j);
        if (sel == 1) return m0 + 8'h80;
        if (sel == 2) return DW'($urandom_range(255, 0));
        return m0;
    endfunction

    // One clock: decide the transfer from pre-edge inputs, then score post-edge outputs.
    task automatic tick();
        logic          pre_rst, pre_clear, pre_acc, pre_pend;
        logic [DW-1:0] pre_data;
        logic [W-1:0]  e;
        logic [W-1:0]  row_e;
        @(negedge clk);
        pre_rst   = rst;
        pre_clear = bus.clear;
        pre_data  = bus.in_data;
        pre_pend  = (exp_q.size() > 0);
        check("in_rdy", 64'(bus.in_rdy), 64'(pre_rst && exp_q.size() <= N));
        pre_acc = pre_rst && bus.in_val && (exp_q.size() <= N) && !pre_clear;
        @(posedge clk);
        #1;
        cycle++;
        if (!pre_rst) begin
            exp_q.delete();
            partial.delete();
            held_row = '0;
            held_idx = '0;
        end else if (pre_pend) begin
            e        = exp_q.pop_front();
            held_row = e[DW*N-1:0];
            held_idx = e[W-1 -: RW];
        end
        check("out_val", 64'(bus.out_val), 64'(pre_rst && pre_pend));
        check("out_last", 64'(bus.out_last), 64'(pre_rst && pre_pend && held_idx == RW'(N - 1)));
        check("out_idx", 64'(bus.out_idx), 64'(held_idx));
        check("out_row", 64'(flat_row()), 64'(held_row));
        if (bus.out_val) begin
            rows_seen++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (bus.out_idx == '0 && first_row_cycle < 0) first_row_cycle = cycle;
        end else begin
            run_len = 0;
        end
        if (pre_rst) begin
            if (pre_clear) begin
                partial.delete();
            end else if (pre_acc) begin
                partial.push_back(pre_data);
                last_acc_cycle = cycle;
                if (partial.size() == N * N) begin
                    for (int r = 0; r < N; r++) begin
                        row_e = '0;
                        row_e[W-1 -: RW] = RW'(r);
                        for (int c = 0; c < N; c++) begin
                            row_e[c*DW +: DW] = partial[r*N + c];
                        end
                        exp_q.push_back(row_e);
                    end
                    partial.delete();
                end
            end
        end
        last_acc = pre_acc;
    endtask

    // driver tasks
    task automatic idle(input int n);
        bus.in_val = 1'b0;
        repeat (n) begin
            bus.in_data = DW'($urandom_range(255, 0));
            tick();
        end
    endtask

    task automatic send_elem(input logic [DW-1:0] d, input int max_gap);
        int  gap;
        bit  done;
        gap  = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        done = 1'b0;
        if (gap > 0) idle(gap);
        bus.in_val  = 1'b1;
        bus.in_data = d;
        for (int t = 0; t < 64 && !done; t++) begin
            tick();
            done = last_acc;
        end
        if (!done) check("accept_timeout", 64'(0), 64'(1));
        bus.in_val = 1'b0;
    endtask

    task automatic send_matrix(input int sel, input int max_gap);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                send_elem(m_elem(sel, i, j), max_gap);
            end
        end
    endtask

    task automatic pulse_clear();
        bus.clear   = 1'b1;
        bus.in_val  = 1'($urandom_range(1, 0));
        bus.in_data = DW'($urandom_range(255, 0));
        tick();
        bus.clear  = 1'b0;
        bus.in_val = 1'b0;
    endtask

    task automatic reset_stats();
        rows_seen       = 0;
        max_run         = 0;
        run_len         = 0;
        first_row_cycle = -1;
    endtask

    initial begin
        bit found;
        held_row    = '0;
        held_idx    = '0;
        rst         = 1'b0;
        bus.clear   = 1'b0;
        bus.in_val  = 1'b1;
        bus.in_data = 8'h5A;

        // reset held with in_val high
        repeat (3) tick();
        rst        = 1'b1;
        bus.in_val = 1'b0;
        idle(2);

        // single matrix: latency, row count, contiguity
        reset_stats();
        send_matrix(0, 0);
        idle(8);
        check("m0_rows", 64'(rows_seen), 64'(N));
        check("m0_contig", 64'(max_run), 64'(N));
        check("m0_latency", 64'(first_row_cycle - last_acc_cycle), 64'(1));

        // two matrices back to back
        reset_stats();
        send_matrix(0, 0);
        send_matrix(1, 0);
        idle(8);
        check("m0m1_rows", 64'(rows_seen), 64'(2 * N));

        // three matrices
        reset_stats();
        send_matrix(0, 0);
        send_matrix(1, 0);
        send_matrix(0, 0);
        idle(8);
        check("m0m1m0_rows", 64'(rows_seen), 64'(3 * N));

        // partial fill discarded by clear
        reset_stats();
        for (int k = 0; k < 6; k++) send_elem(m_elem(0, k / N, k % N), 0);
        bus.clear   = 1'b1;
        bus.in_val  = 1'b1;
        bus.in_data = 8'hEE;
        tick();
        bus.clear  = 1'b0;
        bus.in_val = 1'b0;
        send_matrix(1, 0);
        idle(8);
        check("clear_rows", 64'(rows_seen), 64'(N));

        // reset during row 2 of a drain
        send_matrix(0, 0);
        send_matrix(1, 0);
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            tick();
            found = bus.out_val && (bus.out_idx == RW'(2));
        end
        check("found_row2", 64'(found), 64'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        reset_stats();
        idle(10);
        check("post_reset_rows", 64'(rows_seen), 64'(0));
        send_matrix(0, 1);
        idle(8);
        check("post_reset_m0", 64'(rows_seen), 64'(N));

        // random traffic with clears and resets mixed in
        repeat (40) begin
            case ($urandom_range(9, 0))
                0: begin
                    repeat ($urandom_range(N * N - 1, 1)) send_elem(DW'($urandom_range(255, 0)), 2);
                    pulse_clear();
                end
                1: begin
                    rst = 1'b0;
                    bus.in_val = 1'($urandom_range(1, 0));
                    repeat ($urandom_range(2, 1)) tick();
                    rst = 1'b1;
                    bus.in_val = 1'b0;
                end
                default: send_matrix(2, $urandom_range(3, 0));
            endcase
        end
        idle(10);
        check("final_drain", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
